lcd_write_sequencer: RTL and testbench
======================================

Name: lcd_write_sequencer

Overview:
- Command-layer controller that sequences the LCD transaction layer to paint a full 2x16 character frame from a 256-bit ASCII string. This is the string produced by the hex-to-ASCII converter after an RDID read.
- Issues set-DD-RAM-address and write-data requests one at a time, each closed by the transaction layer's done handshake.
- Sits between the top-level command FSM (start/done) and the transaction block (do_*/\*_done).

Parameters:
- CHARS_PER_LINE, 16, characters written per display line (1..16).
- LINE1_ADDR, 7'h00, DD RAM address of line 1 column 0.
- LINE2_ADDR, 7'h40, DD RAM address of line 2 column 0.
- TIMEOUT_CYCLES, 1_000_000, watchdog limit per handshake (used only with LCD_SEQ_TIMEOUT_EN).

Ports:
- clk  in  1  system clock (DCM-divided clock)
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to write a frame
- ascii_string  in  256  32 chars; char k = ascii_string[255-8k -: 8]; chars 0-15 go to line 1, chars 16-31 to line 2
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the frame is complete (or aborted)
- error  out  1  sticky abort flag (tied 0 without LCD_SEQ_TIMEOUT_EN)
- do_set_dd_ram_addr  out  1  one-cycle request to the transaction layer
- dd_ram_addr  out  7  address held valid from the request until the matching done
- set_dd_ram_addr_done  in  1  transaction-layer completion pulse
- do_write_data  out  1  one-cycle request to the transaction layer
- data_byte  out  8  character held valid from the request until the matching done
- send_data_done  in  1  transaction-layer completion pulse

Behaviour:
- Reset (async, any state):
  - state=IDLE; busy, done, error, do_set_dd_ram_addr, do_write_data = 0; dd_ram_addr=LINE1_ADDR; data_byte=8'h20; counters=0.
  - Reset mid-frame aborts immediately and issues no further requests.
- FSM states: IDLE, SET_ADDR, WAIT_ADDR, WRITE_CHAR, WAIT_CHAR, FINISH.
- IDLE:
  - When start=1, latch ascii_string into an internal 256-bit register, line=0, col=0, go to SET_ADDR.
  - start while not in IDLE is ignored; the latched string is not updated.
- SET_ADDR:
  - Drive dd_ram_addr = (line==0 ? LINE1_ADDR : LINE2_ADDR).
  - Pulse do_set_dd_ram_addr for exactly one cycle, then go to WAIT_ADDR.
- WAIT_ADDR: on set_dd_ram_addr_done=1 go to WRITE_CHAR. send_data_done is ignored in this state.
- WRITE_CHAR:
  - data_byte = latched char (line*16 + col).
  - Pulse do_write_data for one cycle, then go to WAIT_CHAR.
- WAIT_CHAR: on send_data_done=1:
  - If col < CHARS_PER_LINE-1: col+1, go to WRITE_CHAR.
  - Else if line==0: line=1, col=0, go to SET_ADDR.
  - Else go to FINISH.
- FINISH: done=1 for one cycle, busy=0, go to IDLE. A start in the FINISH cycle is ignored.
- Done pulses are sampled only in the WAIT_* states; a done arriving in the same cycle as the request is ignored.
- Latency: exactly one request per handshake. Minimum frame = 2 addr + 32 char handshakes, each ≥2 cycles, plus the FINISH cycle.
- Total requests per frame (default params): 2 address + 32 character; order addr0, c0..c15, addr1, c16..c31.
- Width rules:
  - col is 4 bits and never wraps past CHARS_PER_LINE-1.
  - Char index = {line, col} when CHARS_PER_LINE=16.
  - Chars at or beyond CHARS_PER_LINE within a line are never sent.
- error is cleared on the next accepted start.

Optional Feature:
- Macro LCD_SEQ_TIMEOUT_EN.
- When defined:
  - A 20-bit watchdog counts cycles in WAIT_ADDR/WAIT_CHAR and clears on every state change.
  - On reaching TIMEOUT_CYCLES, set error=1, go to FINISH (done pulses), and issue no further requests.
- When undefined: no watchdog logic; error tied 0; the FSM waits indefinitely.

Test Plan:
- Reset then idle, no start → all outputs at reset values; no do_* pulses over 100 cycles.
- String "MFG:20 TYP:20   CAP:15         ", transaction model acks 3 cycles after each request → sequence addr 0x00, bytes 0x4D,0x46,0x47,...; addr 0x40, bytes 0x43,0x41,0x50,...; exactly 34 requests, one done pulse, busy low after it.
- start re-pulsed mid-frame with a different string → ignored; the original 32 bytes are sent unchanged.
- Ack in the same cycle as do_write_data, plus stray set_dd_ram_addr_done during WAIT_CHAR → both ignored; the sequencer waits for the correct send_data_done.
- Reset asserted after the 5th character ack → outputs return to reset values asynchronously; a new start restarts at addr 0x00, char 0.
- LCD_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=50, model never acks char 3 → error=1 and done pulses 50 cycles after the request; a new start clears error.

Source files
------------

// File: rtl/lcd_write_sequencer.sv
// lcd_write_sequencer: paints a 2x16 character frame from a 256-bit ASCII
// string by issuing set-DD-RAM-address and write-data requests to the LCD
// transaction layer, one at a time, each closed by its done pulse.
// Optional handshake watchdog: define LCD_SEQ_TIMEOUT_EN.
module lcd_write_sequencer #(
  parameter int unsigned CHARS_PER_LINE = 16,
  parameter logic [6:0]  LINE1_ADDR     = 7'h00,
  parameter logic [6:0]  LINE2_ADDR     = 7'h40,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] ascii_string,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic         do_set_dd_ram_addr,
  output logic [6:0]   dd_ram_addr,
  input  logic         set_dd_ram_addr_done,
  output logic         do_write_data,
  output logic [7:0]   data_byte,
  input  logic         send_data_done
);

  typedef enum logic [2:0] {
    IDLE,
    SET_ADDR,
    WAIT_ADDR,
    WRITE_CHAR,
    WAIT_CHAR,
    FINISH
  } state_t;

  localparam logic [3:0] LAST_COL = 4'(CHARS_PER_LINE - 1);

  state_t       state, state_next;
  logic [255:0] str_q;
  logic         line_q, line_next;
  logic [3:0]   col_q, col_next;
  logic [7:0]   data_q;
  logic [7:0]   next_char;
  logic         abort;

  // Char k lives at str[255-8k -: 8]; its low bit offset is 8*(31-k), and
  // 31-k equals ~k for a 5-bit index {line, col}.
  assign next_char = str_q[{~{line_next, col_next}, 3'b000} +: 8];

`ifdef LCD_SEQ_TIMEOUT_EN
  // FINISH lands exactly TIMEOUT_CYCLES cycles after the request: the first
  // wait cycle sees count 0, so the abort decision is taken at limit-2.
  localparam logic [19:0] WD_LIMIT = 20'(TIMEOUT_CYCLES - 2);

  logic [19:0] wd_q;
  logic        error_q;
  logic        waiting;

  assign waiting = (state == WAIT_ADDR) || (state == WAIT_CHAR);
  assign abort   = waiting && (wd_q == WD_LIMIT) &&
                   !((state == WAIT_ADDR) && set_dd_ram_addr_done) &&
                   !((state == WAIT_CHAR) && send_data_done);

  // Watchdog: counts cycles spent in a wait state, cleared on any state change
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    wd_q <= '0;
    else if (state_next != state) wd_q <= '0;
    else if (waiting)             wd_q <= wd_q + 20'd1;
  end

  // Sticky abort flag, cleared by the next accepted start
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        error_q <= 1'b0;
    else if (state == IDLE && start)  error_q <= 1'b0;
    else if (abort)                   error_q <= 1'b1;
  end

  assign error = error_q;
`else
  assign abort = 1'b0;
  assign error = 1'b0;
`endif

  // State, position counters, latched string and held data byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      line_q <= 1'b0;
      col_q  <= '0;
      str_q  <= '0;
      data_q <= 8'h20;
    end else begin
      state  <= state_next;
      line_q <= line_next;
      col_q  <= col_next;
      if (state == IDLE && start)
        str_q <= ascii_string;
      if (state_next == WRITE_CHAR && state != WRITE_CHAR)
        data_q <= next_char;
    end
  end

  // Next-state and position update
  always_comb begin
    state_next = state;
    line_next  = line_q;
    col_next   = col_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SET_ADDR;
          line_next  = 1'b0;
          col_next   = '0;
        end
      end
      SET_ADDR:   state_next = WAIT_ADDR;
      WAIT_ADDR:  if (set_dd_ram_addr_done) state_next = WRITE_CHAR;
      WRITE_CHAR: state_next = WAIT_CHAR;
      WAIT_CHAR: begin
        if (send_data_done) begin
          if (col_q < LAST_COL) begin
            col_next   = col_q + 4'd1;
            state_next = WRITE_CHAR;
          end else if (!line_q) begin
            line_next  = 1'b1;
            col_next   = '0;
            state_next = SET_ADDR;
          end else begin
            state_next = FINISH;
          end
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = FINISH;
  end

  assign busy               = (state == SET_ADDR) || (state == WAIT_ADDR) ||
                              (state == WRITE_CHAR) || (state == WAIT_CHAR);
  assign done               = (state == FINISH);
  assign do_set_dd_ram_addr = (state == SET_ADDR);
  assign do_write_data      = (state == WRITE_CHAR);
  assign dd_ram_addr        = line_q ? LINE2_ADDR : LINE1_ADDR;
  assign data_byte          = data_q;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// tb_lcd_write_sequencer: directed bench with a simple transaction-layer
// model that logs every request and acknowledges it 3 cycles later.
`timescale 1ns/1ps
module tb_lcd_write_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [255:0] ascii_string;
  logic         busy, done, error;
  logic         do_set_dd_ram_addr, do_write_data;
  logic [6:0]   dd_ram_addr;
  logic [7:0]   data_byte;
  logic         set_dd_ram_addr_done, send_data_done;

  logic model_addr_ack, model_data_ack;
  logic inj_addr_ack, inj_data_ack;
  assign set_dd_ram_addr_done = model_addr_ack | inj_addr_ack;
  assign send_data_done       = model_data_ack | inj_data_ack;

  lcd_write_sequencer #(
    .CHARS_PER_LINE(16),
    .LINE1_ADDR(7'h00),
    .LINE2_ADDR(7'h40),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .ascii_string(ascii_string),
    .busy(busy),
    .done(done),
    .error(error),
    .do_set_dd_ram_addr(do_set_dd_ram_addr),
    .dd_ram_addr(dd_ram_addr),
    .set_dd_ram_addr_done(set_dd_ram_addr_done),
    .do_write_data(do_write_data),
    .data_byte(data_byte),
    .send_data_done(send_data_done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transaction-layer model (written only here)
  logic [8:0]  req_log[$];
  int          addr_cd = 0, data_cd = 0;
  int          data_req_cnt = 0, data_ack_cnt = 0, done_cnt = 0;
  int unsigned last_req_cyc = 0;
  // Controlled by the stimulus only
  logic        model_en = 1'b1;
  int          drop_idx = -1;

  always @(negedge clk) begin
    model_addr_ack = 1'b0;
    model_data_ack = 1'b0;
    if (reset) begin
      addr_cd = 0;
      data_cd = 0;
    end else begin
      if (addr_cd > 0) begin
        addr_cd--;
        if (addr_cd == 0) model_addr_ack = 1'b1;
      end
      if (data_cd > 0) begin
        data_cd--;
        if (data_cd == 0) begin
          model_data_ack = 1'b1;
          data_ack_cnt++;
        end
      end
      if (done) done_cnt++;
      if (do_set_dd_ram_addr) begin
        req_log.push_back({2'b10, dd_ram_addr});
        if (model_en) addr_cd = 3;
      end
      if (do_write_data) begin
        req_log.push_back({1'b0, data_byte});
        last_req_cyc = cyc;
        if (model_en && data_req_cnt != drop_idx) data_cd = 3;
        data_req_cnt++;
      end
    end
  end

  int unsigned n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [255:0] s);
    ascii_string = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned limit, input string tag);
    int unsigned n = 0;
    while (!done && n < limit) begin
      tick();
      n++;
    end
    check({tag, " done reached"}, 32'(done), 32'd1);
  endtask

  task automatic check_frame(input int unsigned base, input logic [7:0] ch [32], input string tag);
    logic [8:0] exp;
    check({tag, " request count"}, 32'(req_log.size()) - base, 32'd34);
    for (int k = 0; k < 34; k++) begin
      if (k == 0)       exp = {2'b10, 7'h00};
      else if (k == 17) exp = {2'b10, 7'h40};
      else if (k < 17)  exp = {1'b0, ch[k-1]};
      else              exp = {1'b0, ch[k-2]};
      if (base + k < 32'(req_log.size()))
        check($sformatf("%s req%0d", tag, k), 32'(req_log[base+k]), 32'(exp));
    end
  endtask

  function automatic logic [255:0] pack(input logic [7:0] ch [32]);
    logic [255:0] v;
    for (int k = 0; k < 32; k++) v[255-8*k -: 8] = ch[k];
    return v;
  endfunction

  logic [7:0]  ca [32];
  logic [7:0]  cb [32];
  int unsigned base;
  int          snap;
  int unsigned n;

  initial begin
    string sa, sb;
    sa = "MFG:20 TYP:20   CAP:15";
    sb = "ABCDEFGHIJKLMNOPQRSTUVWXYZ012345";
    for (int k = 0; k < 32; k++) begin
      ca[k] = (k < sa.len()) ? sa[k] : 8'h20;
      cb[k] = sb[k];
    end

    reset = 1'b1; start = 1'b0; ascii_string = '0;
    inj_addr_ack = 1'b0; inj_data_ack = 1'b0;
    repeat (3) tick();

    // Reset values
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst error", 32'(error), 0);
    check("rst do_set", 32'(do_set_dd_ram_addr), 0);
    check("rst do_write", 32'(do_write_data), 0);
    check("rst dd_ram_addr", 32'(dd_ram_addr), 32'h00);
    check("rst data_byte", 32'(data_byte), 32'h20);

    // Idle without start: no requests for 100 cycles
    reset = 1'b0;
    base = req_log.size();
    snap = done_cnt;
    repeat (100) tick();
    check("idle requests", 32'(req_log.size()) - base, 0);
    check("idle done pulses", 32'(done_cnt - snap), 0);
    check("idle busy", 32'(busy), 0);

    // Full frame with 3-cycle acks
    base = req_log.size();
    snap = done_cnt;
    pulse_start(pack(ca));
    check("frameA busy after start", 32'(busy), 1);
    check("frameA do_set first cycle", 32'(do_set_dd_ram_addr), 1);
    check("frameA addr first cycle", 32'(dd_ram_addr), 32'h00);
    tick();
    check("frameA do_set one cycle", 32'(do_set_dd_ram_addr), 0);
    wait_done(400, "frameA");
    check("frameA busy at done", 32'(busy), 0);
    tick();
    check("frameA done one cycle", 32'(done), 0);
    check("frameA busy after done", 32'(busy), 0);
    check("frameA done pulses", 32'(done_cnt - snap), 1);
    check_frame(base, ca, "frameA");

    // Start re-pulsed mid-frame with another string is ignored
    base = req_log.size();
    snap = done_cnt;
    pulse_start(pack(ca));
    repeat (20) tick();
    pulse_start(pack(cb));
    wait_done(400, "restart");
    repeat (10) tick();
    check_frame(base, ca, "restart");
    check("restart done pulses", 32'(done_cnt - snap), 1);
    check("restart busy", 32'(busy), 0);

    // Same-cycle data ack and stray address ack are ignored
    model_en = 1'b0;
    base = req_log.size();
    pulse_start(pack(cb));
    tick();                       // WAIT_ADDR
    inj_addr_ack = 1'b1;
    tick();                       // WRITE_CHAR for char 0
    inj_addr_ack = 1'b0;
    check("manual do_write", 32'(do_write_data), 1);
    check("manual char0", 32'(data_byte), 32'(cb[0]));
    inj_data_ack = 1'b1;          // same cycle as the request
    tick();                       // WAIT_CHAR
    inj_data_ack = 1'b0;
    inj_addr_ack = 1'b1;          // stray address ack
    tick();
    inj_addr_ack = 1'b0;
    repeat (5) tick();
    check("manual requests while waiting", 32'(req_log.size()) - base, 2);
    check("manual busy while waiting", 32'(busy), 1);
    check("manual data held", 32'(data_byte), 32'(cb[0]));
    inj_data_ack = 1'b1;
    tick();
    inj_data_ack = 1'b0;
    check("manual next do_write", 32'(do_write_data), 1);
    check("manual char1", 32'(data_byte), 32'(cb[1]));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_en = 1'b1;
    tick();

    // Asynchronous reset after the 5th character ack
    base = req_log.size();
    snap = data_ack_cnt;
    pulse_start(pack(ca));
    n = 0;
    while (data_ack_cnt < snap + 5 && n < 200) begin
      tick();
      n++;
    end
    check("abort 5 acks seen", 32'(data_ack_cnt - snap), 5);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort busy", 32'(busy), 0);
    check("abort do_write", 32'(do_write_data), 0);
    check("abort do_set", 32'(do_set_dd_ram_addr), 0);
    check("abort data_byte", 32'(data_byte), 32'h20);
    check("abort dd_ram_addr", 32'(dd_ram_addr), 32'h00);
    check("abort requests", 32'(req_log.size()) - base, 6);
    repeat (3) tick();
    reset = 1'b0;
    repeat (5) tick();
    check("abort no requests after", 32'(req_log.size()) - base, 6);
    base = req_log.size();
    pulse_start(pack(ca));
    wait_done(400, "after abort");
    tick();
    check_frame(base, ca, "after abort");

`ifdef LCD_SEQ_TIMEOUT_EN
    // Char 3 is never acked: watchdog aborts the frame
    base = req_log.size();
    drop_idx = data_req_cnt + 3;
    pulse_start(pack(ca));
    wait_done(400, "timeout");
    check("timeout error at done", 32'(error), 1);
    check("timeout latency", cyc - last_req_cyc, 50);
    check("timeout requests", 32'(req_log.size()) - base, 5);
    tick();
    check("timeout error sticky", 32'(error), 1);
    check("timeout busy", 32'(busy), 0);
    repeat (10) tick();
    check("timeout no more requests", 32'(req_log.size()) - base, 5);
    drop_idx = -1;
    pulse_start(pack(ca));
    check("timeout error cleared", 32'(error), 0);
    wait_done(400, "after timeout");
    check("after timeout error", 32'(error), 0);
    tick();
`else
    check("error tied low", 32'(error), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
